// File: rtl/pbit_sweep_scheduler.sv
// Sequences colour groups with per-group dwell, counts sweeps, and captures m_in one cycle after each sweep end.
// Outputs registered (group enable from cycle after start). One-entry sample buffer: a capture while full drops the sample and sets overflow.
module pbit_sweep_scheduler #(
    parameter int NUM_GROUPS = 5,
    parameter int DWELL_W    = 4,
    parameter int SWEEP_W    = 16,
    parameter int OUT_W      = 8,
    localparam int GW        = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [SWEEP_W-1:0] num_sweeps,
    input  logic [OUT_W-1:0]   m_in,
    output logic [GW-1:0]      group_idx,
    output logic               group_en,
    output logic               busy,
    output logic               done,
    output logic [SWEEP_W-1:0] sweep_count,
    output logic [OUT_W-1:0]   sample_data,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               overflow
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [GW-1:0]      group_idx_q, group_idx_d;
    logic               group_en_q, group_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] dcnt_q, dcnt_d;
    logic [SWEEP_W-1:0] num_q, num_d;
    logic [SWEEP_W-1:0] sweep_count_q, sweep_count_d;
    logic               stop_pend_q, stop_pend_d;
    logic               cap_q, cap_d;
    logic [OUT_W-1:0]   sample_data_q, sample_data_d;
    logic               sample_valid_q, sample_valid_d;
    logic               overflow_q, overflow_d;

    logic               xfer;
    logic               last_dwell;
    logic               last_group;
    logic [SWEEP_W-1:0] sweep_inc;

    always_comb begin
        state_d        = state_q;
        group_idx_d    = group_idx_q;
        group_en_d     = group_en_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        dwell_d        = dwell_q;
        dcnt_d         = dcnt_q;
        num_d          = num_q;
        sweep_count_d  = sweep_count_q;
        stop_pend_d    = stop_pend_q;
        cap_d          = 1'b0;
        sample_data_d  = sample_data_q;
        sample_valid_d = sample_valid_q;
        overflow_d     = overflow_q;

        xfer       = sample_valid_q & sample_ready;
        last_dwell = (dcnt_q == dwell_q - DWELL_W'(1));
        last_group = (group_idx_q == GW'(NUM_GROUPS - 1));
        sweep_inc  = (&sweep_count_q) ? sweep_count_q : sweep_count_q + SWEEP_W'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dwell_d       = (dwell == '0) ? DWELL_W'(1) : dwell;
                    num_d         = num_sweeps;
                    sweep_count_d = '0;
                    overflow_d    = 1'b0;
                    stop_pend_d   = 1'b0;
                    dcnt_d        = '0;
                    group_idx_d   = '0;
                    group_en_d    = 1'b1;
                    busy_d        = 1'b1;
                    state_d       = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (last_dwell) begin
                    dcnt_d = '0;
                    if (last_group) begin
                        group_idx_d   = '0;
                        sweep_count_d = sweep_inc;
                        cap_d         = 1'b1;
                        // A stop arriving on the sweep-end edge itself still ends this sweep.
                        if (((num_q != '0) && (sweep_inc == num_q)) || stop_pend_q || stop) begin
                            group_en_d  = 1'b0;
                            stop_pend_d = 1'b0;
                            state_d     = S_FLUSH;
                        end
                    end else begin
                        group_idx_d = group_idx_q + GW'(1);
                    end
                end else begin
                    dcnt_d = dcnt_q + DWELL_W'(1);
                end
            end
            S_FLUSH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A consumer accept on the capture edge frees the slot for the new sample.
        if (cap_q) begin
            if (!sample_valid_q || xfer) begin
                sample_data_d  = m_in;
                sample_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (xfer) begin
            sample_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            group_idx_q    <= '0;
            group_en_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            dwell_q        <= '0;
            dcnt_q         <= '0;
            num_q          <= '0;
            sweep_count_q  <= '0;
            stop_pend_q    <= 1'b0;
            cap_q          <= 1'b0;
            sample_data_q  <= '0;
            sample_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            group_idx_q    <= group_idx_d;
            group_en_q     <= group_en_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            dwell_q        <= dwell_d;
            dcnt_q         <= dcnt_d;
            num_q          <= num_d;
            sweep_count_q  <= sweep_count_d;
            stop_pend_q    <= stop_pend_d;
            cap_q          <= cap_d;
            sample_data_q  <= sample_data_d;
            sample_valid_q <= sample_valid_d;
            overflow_q     <= overflow_d;
        end
    end

    assign group_idx    = group_idx_q;
    assign group_en     = group_en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign sweep_count  = sweep_count_q;
    assign sample_data  = sample_data_q;
    assign sample_valid = sample_valid_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_pbit_sweep_scheduler.sv
// Directed bench for pbit_sweep_scheduler with a sample scoreboard checked on every buffer transfer.
module tb_pbit_sweep_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop;
    logic [3:0]  dwell;
    logic [15:0] num_sweeps;
    logic [7:0]  m_in;
    logic [2:0]  group_idx;
    logic        group_en, busy, done;
    logic [15:0] sweep_count;
    logic [7:0]  sample_data;
    logic        sample_valid, sample_ready, overflow;

    int checks = 0;
    int failures = 0;
    int en_cnt, done_cnt, vpulses, done_k, last_en_k;
    logic prev_valid;
    logic [7:0] sbq[$];

    always #5 clk = ~clk;

    pbit_sweep_scheduler dut (
        .clk(clk), .reset(rst), .start(start), .stop(stop), .dwell(dwell),
        .num_sweeps(num_sweeps), .m_in(m_in), .group_idx(group_idx),
        .group_en(group_en), .busy(busy), .done(done), .sweep_count(sweep_count),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; a transfer seen before the edge pops the scoreboard.
    task automatic step();
        logic       x;
        logic [7:0] xd;
        logic [7:0] e;
        x  = sample_valid && sample_ready;
        xd = sample_data;
        @(posedge clk);
        #1;
        if (x) begin
            if (sbq.size() == 0) chk("sb_unexpected_xfer", 32'(xd), 32'hFFFF_FFFF);
            else begin
                e = sbq.pop_front();
                chk("sample_xfer", 32'(xd), 32'(e));
            end
        end
        if (done) done_cnt++;
        if (group_en) en_cnt++;
        if (sample_valid && !prev_valid) vpulses++;
        prev_valid = sample_valid;
    endtask

    task automatic kick(input logic [3:0] dw, input logic [15:0] ns, input logic stp);
        dwell = dw; num_sweeps = ns; start = 1'b1; stop = stp;
        en_cnt = 0; done_cnt = 0; vpulses = 0; prev_valid = sample_valid;
        step();
        start = 1'b0; stop = 1'b0;
        chk("kick_group_en", 32'(group_en), 32'd1);
        chk("kick_group_idx", 32'(group_idx), 32'd0);
        chk("kick_busy", 32'(busy), 32'd1);
        chk("kick_sweep_count", 32'(sweep_count), 32'd0);
    endtask

    task automatic run(input int ncyc, input int dwe,
                       input int mk1, input logic [7:0] mv1,
                       input int mk2, input logic [7:0] mv2,
                       input int rk_on, input int rk_off, input int sk, input int pk);
        int ei;
        ei = 1;
        done_k = -1; last_en_k = -1;
        for (int k = 1; k <= ncyc; k++) begin
            step();
            if (group_en) begin
                chk("group_idx", 32'(group_idx), 32'((ei / dwe) % 5));
                ei++;
                last_en_k = k;
            end
            if (done && done_k < 0) done_k = k;
            if (k == mk1) m_in = mv1;
            if (k == mk2) m_in = mv2;
            start = (k == sk);
            stop  = (k == pk);
            if (k == rk_on) sample_ready = 1'b1;
            if (k == rk_off) sample_ready = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; dwell = 4'd0; num_sweeps = 16'd0;
        m_in = 8'd0; sample_ready = 1'b0; prev_valid = 1'b0;
        en_cnt = 0; done_cnt = 0; vpulses = 0; done_k = -1; last_en_k = -1;
        #2;
        chk("rst_group_idx", 32'(group_idx), 32'd0);
        chk("rst_group_en", 32'(group_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sweep_count", 32'(sweep_count), 32'd0);
        chk("rst_sample_valid", 32'(sample_valid), 32'd0);
        chk("rst_sample_data", 32'(sample_data), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        #10 rst = 1'b0;
        step();

        // Basic run: dwell 2, two sweeps, consumer always ready.
        sample_ready = 1'b1; m_in = 8'h11;
        sbq.push_back(8'h11); sbq.push_back(8'h22);
        kick(4'd2, 16'd2, 1'b0);
        run(25, 2, 11, 8'h22, -1, 8'h00, -1, -1, -1, -1);
        chk("t1_en_cycles", 32'(en_cnt), 32'd20);
        chk("t1_valid_pulses", 32'(vpulses), 32'd2);
        chk("t1_done_k", 32'(done_k), 32'd21);
        chk("t1_done_after_last_en", 32'(done_k - last_en_k), 32'd2);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_sweep_count", 32'(sweep_count), 32'd2);
        chk("t1_busy", 32'(busy), 32'd0);

        // dwell 0 behaves as 1.
        m_in = 8'hA5; sbq.push_back(8'hA5);
        kick(4'd0, 16'd1, 1'b0);
        run(10, 1, -1, 8'h00, -1, 8'h00, -1, -1, -1, -1);
        chk("t2_en_cycles", 32'(en_cnt), 32'd5);
        chk("t2_done_k", 32'(done_k), 32'd6);
        chk("t2_done_cnt", 32'(done_cnt), 32'd1);
        chk("t2_sweep_count", 32'(sweep_count), 32'd1);
        chk("t2_sample_data", 32'(sample_data), 32'hA5);

        // Backpressure: later samples are dropped and overflow sticks.
        sample_ready = 1'b0; m_in = 8'h01; sbq.push_back(8'h01);
        kick(4'd1, 16'd3, 1'b0);
        run(18, 1, 6, 8'h02, 11, 8'h03, -1, -1, -1, -1);
        chk("t3_sample_data", 32'(sample_data), 32'h01);
        chk("t3_sample_valid", 32'(sample_valid), 32'd1);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_sweep_count", 32'(sweep_count), 32'd3);
        chk("t3_en_cycles", 32'(en_cnt), 32'd15);
        chk("t3_done_k", 32'(done_k), 32'd16);
        sample_ready = 1'b1;
        step();
        sample_ready = 1'b0;
        chk("t3_valid_after_xfer", 32'(sample_valid), 32'd0);
        chk("t3_overflow_sticky", 32'(overflow), 32'd1);

        // Accept and capture on the same edge.
        m_in = 8'h01; sbq.push_back(8'h01); sbq.push_back(8'h02);
        kick(4'd1, 16'd2, 1'b0);
        chk("t4_overflow_cleared", 32'(overflow), 32'd0);
        run(14, 1, 6, 8'h02, -1, 8'h00, 10, 11, -1, -1);
        chk("t4_sample_data", 32'(sample_data), 32'h02);
        chk("t4_sample_valid", 32'(sample_valid), 32'd1);
        chk("t4_overflow", 32'(overflow), 32'd0);
        chk("t4_done_k", 32'(done_k), 32'd11);
        sample_ready = 1'b1;
        step();
        chk("t4_drained", 32'(sample_valid), 32'd0);

        // Free-run with stop; start while busy and stop with the idle start are ignored.
        m_in = 8'h5C;
        for (int i = 0; i < 4; i++) sbq.push_back(8'h5C);
        kick(4'd1, 16'd0, 1'b1);
        dwell = 4'd7; num_sweeps = 16'd1;
        run(40, 1, -1, 8'h00, -1, 8'h00, -1, -1, 3, 17);
        chk("t5_sweep_count", 32'(sweep_count), 32'd4);
        chk("t5_en_cycles", 32'(en_cnt), 32'd20);
        chk("t5_last_en_k", 32'(last_en_k), 32'd19);
        chk("t5_done_k", 32'(done_k), 32'd21);
        chk("t5_done_cnt", 32'(done_cnt), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-dwell with a full sample buffer.
        sample_ready = 1'b0; m_in = 8'h77;
        kick(4'd2, 16'd2, 1'b0);
        run(13, 2, -1, 8'h00, -1, 8'h00, -1, -1, -1, -1);
        chk("t6_pre_sweep_count", 32'(sweep_count), 32'd1);
        chk("t6_pre_valid", 32'(sample_valid), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_group_en", 32'(group_en), 32'd0);
        chk("t6_rst_group_idx", 32'(group_idx), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_sweep_count", 32'(sweep_count), 32'd0);
        chk("t6_rst_sample_valid", 32'(sample_valid), 32'd0);
        chk("t6_rst_sample_data", 32'(sample_data), 32'd0);
        done_cnt = 0; prev_valid = 1'b0;
        step();
        step();
        #3 rst = 1'b0;
        step();
        chk("t6_no_done", 32'(done_cnt), 32'd0);
        sample_ready = 1'b1; m_in = 8'h3C; sbq.push_back(8'h3C);
        kick(4'd1, 16'd1, 1'b0);
        run(10, 1, -1, 8'h00, -1, 8'h00, -1, -1, -1, -1);
        chk("t6_sweep_count", 32'(sweep_count), 32'd1);
        chk("t6_done_cnt", 32'(done_cnt), 32'd1);
        chk("t6_en_cycles", 32'(en_cnt), 32'd5);
        chk("sb_empty_at_end", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
